// File: rtl/tff_pkg.sv
// Shared constants for the toggle-flip-flop counter: parameter legality
// limits, direction encodings and a helper for the largest legal count.
package tff_pkg;

    localparam int   WIDTH_MIN = 1;
    localparam int   WIDTH_MAX = 32;

    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;

    // Largest value representable in 'width' bits (computed in 64 bits so
    // that width=32 does not overflow).
    function automatic longint unsigned max_limit(input int width);
        return (64'd1 << width) - 64'd1;
    endfunction

    // True when the WIDTH/MAX pair describes a buildable counter.
    function automatic bit params_legal(input int width, input longint unsigned max);
        return (width >= WIDTH_MIN) && (width <= WIDTH_MAX) &&
               (max >= 64'd1) && (max <= max_limit(width));
    endfunction

endpackage

// File: rtl/tff_cell.sv
// One counter bit: a T flip-flop with asynchronous active-low reset and a
// synchronous override (ld/d) that wins over the toggle input.
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    input  logic ld,
    input  logic d,
    output logic q,
    output logic qb
);

    // Reset clears the bit; otherwise override loads d, else toggle on t.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= 1'b0;
        end else if (ld) begin
            q <= d;
        end else if (t) begin
            q <= ~q;
        end
    end

    assign qb = ~q;

endmodule

// File: rtl/tff_counter.sv
// Up/down counter built from toggle cells. Ordinary counting is done purely
// by the toggle chain; clear, load, and limit handling (wrap or hold) go
// through the synchronous override path of every cell.
module tff_counter
    import tff_pkg::*;
#(
    parameter int              WIDTH    = 4,
    parameter longint unsigned MAX      = (64'd1 << WIDTH) - 64'd1,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX);

    generate
        if (!params_legal(WIDTH, MAX)) begin : g_bad_params
            $error("tff_counter: illegal WIDTH/MAX combination");
        end
    endgenerate

    logic [WIDTH-1:0] carry_up;     // all lower bits are 1
    logic [WIDTH-1:0] carry_dn;     // all lower bits are 0
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] ovr_d_next;
    logic             ovr_ld_next;
    logic             ovf_reg;

    // Terminal count depends only on q and direction, never on en.
    assign tc = ((up == UP)   && (q == MAX_Q)) ||
                ((up == DOWN) && (q == '0));

    assign carry_up[0] = 1'b1;
    assign carry_dn[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 1; gi < WIDTH; gi++) begin : g_carry
            assign carry_up[gi] = carry_up[gi-1] &  q[gi-1];
            assign carry_dn[gi] = carry_dn[gi-1] & ~q[gi-1];
        end

        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            assign toggle[gi] = en & ((up == UP) ? carry_up[gi] : carry_dn[gi]);

            tff_cell u_cell (
                .clk (clk),
                .rst (rst),
                .t   (toggle[gi]),
                .ld  (ovr_ld_next),
                .d   (ovr_d_next[gi]),
                .q   (q[gi]),
                .qb  (qb[gi])
            );
        end
    endgenerate

    // Override decode in priority order: clear, clamped load, limit event.
    // Below the limit the toggle chain alone produces q+1 / q-1.
    always_comb begin
        ovr_ld_next = 1'b0;
        ovr_d_next  = q;
        if (clr) begin
            ovr_ld_next = 1'b1;
            ovr_d_next  = '0;
        end else if (load) begin
            ovr_ld_next = 1'b1;
            ovr_d_next  = (din > MAX_Q) ? MAX_Q : din;
        end else if (en && tc) begin
            ovr_ld_next = 1'b1;
            if (SATURATE) begin
                ovr_d_next = q;
            end else begin
                ovr_d_next = (up == UP) ? '0 : MAX_Q;
            end
        end
    end

    // Flag every counting edge that hits a limit (wrapped or blocked).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_reg <= 1'b0;
        end else begin
            ovf_reg <= en & tc & ~clr & ~load;
        end
    end

    assign ovf = ovf_reg;

endmodule

// File: tb/tb_tff_counter.sv
// Directed bench for tff_counter (WIDTH=4, MAX=9): one wrapping and one
// saturating instance share the same stimulus.
module tb_tff_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [3:0] din = 4'd0;
    logic       en = 1'b0;
    logic       up = 1'b1;

    logic [3:0] q0, qb0, q1, qb1;
    logic       tc0, ovf0, tc1, ovf1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tff_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .din(din),
        .en(en), .up(up), .q(q0), .qb(qb0), .tc(tc0), .ovf(ovf0)
    );

    tff_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .din(din),
        .en(en), .up(up), .q(q1), .qb(qb1), .tc(tc1), .ovf(ovf1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok %s = %0h", tag, got);
        end
    endtask

    // One rising edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] wrap_q   [12];
        logic       wrap_ovf [12];
        logic [3:0] sd_q1    [4];
        logic       sd_ovf1  [4];
        logic [3:0] sd_q0    [4];
        logic       sd_ovf0  [4];
        logic [3:0] dir_q    [5];
        logic       dir_up   [5];

        wrap_q   = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
        wrap_ovf = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        sd_q1    = '{4'd1, 4'd0, 4'd0, 4'd0};
        sd_ovf1  = '{0, 0, 1, 1};
        sd_q0    = '{4'd1, 4'd0, 4'd9, 4'd8};
        sd_ovf0  = '{0, 0, 1, 0};
        dir_q    = '{4'd5, 4'd6, 4'd5, 4'd4, 4'd3};
        dir_up   = '{1, 1, 0, 0, 0};

        // Power-on reset, with counting requested during reset.
        #2 rst = 1'b0;
        #1;
        check_eq("reset_q", {28'd0, q0}, 32'd0);
        check_eq("reset_qb", {28'd0, qb0}, 32'hF);
        check_eq("reset_ovf", {31'd0, ovf0}, 32'd0);
        en = 1'b1;
        step();
        step();
        check_eq("reset_hold_q", {28'd0, q0}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;

        // Async reset from q=5 without a clock edge.
        load = 1'b1; din = 4'd5;
        step();
        load = 1'b0;
        check_eq("pre_async_q", {28'd0, q0}, 32'd5);
        #2 rst = 1'b0;
        #1;
        check_eq("async_q", {28'd0, q0}, 32'd0);
        check_eq("async_qb", {28'd0, qb0}, 32'hF);
        check_eq("async_ovf", {31'd0, ovf0}, 32'd0);
        #2 rst = 1'b1;

        // Wrap up through MAX on the wrapping instance.
        clr = 1'b1;
        step();
        clr = 1'b0;
        up = 1'b1; en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            check_eq($sformatf("wrap_q[%0d]", k), {28'd0, q0}, {28'd0, wrap_q[k]});
            check_eq($sformatf("wrap_ovf[%0d]", k), {31'd0, ovf0}, {31'd0, wrap_ovf[k]});
            check_eq($sformatf("wrap_tc[%0d]", k), {31'd0, tc0}, (wrap_q[k] == 4'd9) ? 32'd1 : 32'd0);
        end

        // Saturate down from 2 (wrapping instance wraps to MAX instead).
        en = 1'b0; load = 1'b1; din = 4'd2;
        step();
        load = 1'b0;
        check_eq("sd_load_q", {28'd0, q1}, 32'd2);
        up = 1'b0; en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq($sformatf("sd_sat_q[%0d]", k), {28'd0, q1}, {28'd0, sd_q1[k]});
            check_eq($sformatf("sd_sat_ovf[%0d]", k), {31'd0, ovf1}, {31'd0, sd_ovf1[k]});
            check_eq($sformatf("sd_wrap_q[%0d]", k), {28'd0, q0}, {28'd0, sd_q0[k]});
            check_eq($sformatf("sd_wrap_ovf[%0d]", k), {31'd0, ovf0}, {31'd0, sd_ovf0[k]});
        end

        // Async reset also clears a set ovf.
        #2 rst = 1'b0;
        #1;
        check_eq("async_ovf_set", {31'd0, ovf1}, 32'd0);
        check_eq("async_q_sat", {28'd0, q1}, 32'd0);
        #2 rst = 1'b1;

        // Priority: clear beats load and en; then clamped load.
        clr = 1'b1; load = 1'b1; din = 4'd7; en = 1'b1; up = 1'b1;
        step();
        check_eq("prio_clr_q", {28'd0, q0}, 32'd0);
        check_eq("prio_clr_ovf", {31'd0, ovf0}, 32'd0);
        clr = 1'b0; din = 4'd12;
        step();
        check_eq("prio_clamp_q", {28'd0, q0}, 32'd9);
        check_eq("prio_clamp_qb", {28'd0, qb0}, 32'd6);
        check_eq("prio_load_ovf", {31'd0, ovf0}, 32'd0);
        load = 1'b0; en = 1'b0;

        // Mid-count direction change from 4.
        load = 1'b1; din = 4'd4;
        step();
        load = 1'b0; en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            up = dir_up[k];
            #1;
            check_eq($sformatf("dir_tc_pre[%0d]", k), {31'd0, tc0}, 32'd0);
            step();
            check_eq($sformatf("dir_q[%0d]", k), {28'd0, q0}, {28'd0, dir_q[k]});
            check_eq($sformatf("dir_ovf[%0d]", k), {31'd0, ovf0}, 32'd0);
        end

        // en gating at MAX.
        en = 1'b0; up = 1'b1; load = 1'b1; din = 4'd9;
        step();
        load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq($sformatf("gate_q[%0d]", k), {28'd0, q0}, 32'd9);
            check_eq($sformatf("gate_tc[%0d]", k), {31'd0, tc0}, 32'd1);
            check_eq($sformatf("gate_ovf[%0d]", k), {31'd0, ovf0}, 32'd0);
        end
        up = 1'b0;
        #1;
        check_eq("gate_tc_down", {31'd0, tc0}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tff_counter.md
TFF_COUNTER -- requirements
Module: tff_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter width in bits, legal range 1..32.
REQ-002 SHALL have parameter MAX, default 2**WIDTH-1: terminal count, legal range 1..2**WIDTH-1.
REQ-003 SHALL have parameter SATURATE, default 0: 0 = wrap at the limits, 1 = hold at the limits.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port clr, input, 1: synchronous clear.
REQ-007 SHALL have port load, input, 1: synchronous load of din.
REQ-008 SHALL have port din, input, WIDTH: load value.
REQ-009 SHALL have port en, input, 1: count enable.
REQ-010 SHALL have port up, input, 1: direction, 1 = up, 0 = down.
REQ-011 SHALL have port q, output, WIDTH: count value.
REQ-012 SHALL have port qb, output, WIDTH: bitwise complement of q.
REQ-013 SHALL have port tc, output, 1: terminal count for the current direction.
REQ-014 SHALL have port ovf, output, 1: registered limit-event flag.

Function
REQ-015 SHALL apply one operation per rising clk edge, in priority order: clr, then load, then en; with none asserted, q holds.
REQ-016 SHALL set q to 0 on an edge where clr=1, regardless of load, en and up.
REQ-017 SHALL load q with din on an edge where load=1 and clr=0; if din > MAX, q SHALL load MAX.
REQ-018 SHALL, on an edge where only en=1 and up=1, set q to q+1 if q < MAX.
REQ-019 SHALL, on an edge where only en=1 and up=0, set q to q-1 if q > 0.
REQ-020 SHALL, at a limit with en=1, set q per SATURATE: SATURATE=0 wraps MAX->0 going up and 0->MAX going down; SATURATE=1 holds q.
REQ-021 SHALL drive qb = ~q combinationally at all times, including during reset.
REQ-022 SHALL drive tc combinationally from q and up: tc = (up and q==MAX) or (not up and q==0); tc does not depend on en.
REQ-023 SHALL register ovf: ovf=1 for the cycle after an edge where en=1, tc=1, clr=0 and load=0; otherwise ovf=0.
REQ-024 SHALL assert ovf on every blocked cycle while saturated with en held high, not just the first.
REQ-025 SHALL implement each count bit as a toggle element: bit i toggles when en and every lower bit is 1 (up) or 0 (down); the limit and wrap correction SHALL use a synchronous override path (clr/load/limit) into the same element.
REQ-026 SHALL have one-cycle latency from any input to q; direction changes take effect on the same edge as the en they accompany.
REQ-027 SHALL not produce X on q for a parameter set inside the legal range; MAX outside the legal range SHALL be rejected at elaboration.

Reset
REQ-028 SHALL, on rst=0, asynchronously force q=0, qb=all-ones and ovf=0, independent of clk.
REQ-029 SHALL hold those values while rst=0 and take the first operation on the first rising clk edge after rst rises.
REQ-030 SHALL abandon any operation in progress when rst asserts mid-count; no partial update survives.

Structure
REQ-031 SHALL place the WIDTH/MAX legality check constants and the direction encodings (UP=1, DOWN=0) in shared package tff_pkg.
REQ-032 SHALL instantiate WIDTH copies of sub-module tff_cell: a 1-bit T flip-flop with async active-low rst, toggle input t, synchronous override (ld, d), and outputs q and qb.
REQ-033 SHALL keep next-state decode (priority, limit detection, clamp) in tff_counter, with no logic inside tff_cell beyond toggle/override/reset.

Verification (WIDTH=4, MAX=9)
REQ-034 SHALL verify the async reset: rst=0 between clock edges with q=5 -> q=0, qb=4'hF and ovf=0 immediately, with no clk edge needed.
REQ-035 SHALL verify the wrap-up: SATURATE=0, up=1, en=1 for 12 edges from 0 -> q runs 1..9,0,1,2; tc=1 while q=9; ovf=1 exactly one cycle, after the 9->0 edge.
REQ-036 SHALL verify the saturate-down: SATURATE=1, load din=2, then up=0, en=1 for 4 edges -> q=2,1,0,0,0; ovf=1 on the last two cycles.
REQ-037 SHALL verify priority: clr=1, load=1, din=7 and en=1 on one edge -> q=0; next edge load=1, din=12 -> q=9 (clamped).
REQ-038 SHALL verify a mid-count direction change: q=4, up=1 for 2 edges then up=0 for 3 edges -> q=5,6,5,4,3; tc stays 0 and ovf stays 0.
REQ-039 SHALL verify the en gating: q=9, up=1, en=0 for 3 edges -> q stays 9, tc=1, ovf=0.
